// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is computed at acceptance
// and committed after a fixed busy window. Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module ex_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_busy,
  output logic        o_stall_req,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_shadow;
  logic          r_div0;

  logic          w_is_mult;
  logic          w_is_div;
  logic          w_mul_signed;
  logic          w_long_op;
  logic [CW-1:0] w_cycles;
  logic [63:0]   w_a64;
  logic [63:0]   w_b64;
  logic [63:0]   w_prod;
  logic          w_div_signed;
  logic          w_rs_neg;
  logic          w_rt_neg;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;
  logic [31:0]   w_divisor;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic [31:0]   w_q;
  logic [31:0]   w_r;
  logic [63:0]   w_shadow;
`ifdef MULDIV_MADD_EN
  logic          w_is_acc;
  logic          w_acc_sub;
  logic [63:0]   w_acc;
`endif

  assign w_is_mult = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div  = (i_op == OP_DIV)  || (i_op == OP_DIVU);

`ifdef MULDIV_MADD_EN
  assign w_is_acc     = (i_op == OP_MADD) || (i_op == OP_MADDU) || (i_op == OP_MSUB) || (i_op == OP_MSUBU);
  assign w_acc_sub    = (i_op == OP_MSUB) || (i_op == OP_MSUBU);
  assign w_mul_signed = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_MSUB);
  assign w_long_op    = w_is_mult || w_is_div || w_is_acc;
  assign w_acc        = w_acc_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`else
  assign w_mul_signed = (i_op == OP_MULT);
  assign w_long_op    = w_is_mult || w_is_div;
`endif

  assign w_cycles = w_is_div ? DIV_N : MULT_N;

  // Operands are extended to 64 bits so a single multiplier covers signed and unsigned.
  assign w_a64  = w_mul_signed ? {{32{i_rs[31]}}, i_rs} : {32'd0, i_rs};
  assign w_b64  = w_mul_signed ? {{32{i_rt[31]}}, i_rt} : {32'd0, i_rt};
  assign w_prod = w_a64 * w_b64;

  // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign w_div_signed = (i_op == OP_DIV);
  assign w_rs_neg     = w_div_signed & i_rs[31];
  assign w_rt_neg     = w_div_signed & i_rt[31];
  assign w_abs_a      = w_rs_neg ? (~i_rs + 32'd1) : i_rs;
  assign w_abs_b      = w_rt_neg ? (~i_rt + 32'd1) : i_rt;
  assign w_divisor    = (i_rt == 32'd0) ? 32'd1 : w_abs_b;
  assign w_uq         = w_abs_a / w_divisor;
  assign w_ur         = w_abs_a % w_divisor;
  assign w_q          = (w_rs_neg ^ w_rt_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_r          = w_rs_neg ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    w_shadow = w_prod;
    if (w_is_div) w_shadow = {w_r, w_q};
`ifdef MULDIV_MADD_EN
    if (w_is_acc) w_shadow = w_acc;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_shadow <= 64'd0;
      r_div0   <= 1'b0;
    end else if (r_busy) begin
      // New starts are ignored for the whole window, including the commit edge.
      if (r_cnt == CNT_ONE) begin
        if (!r_div0) begin
          r_hi <= r_shadow[63:32];
          r_lo <= r_shadow[31:0];
        end
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end else if (i_start) begin
      if (w_long_op) begin
        r_shadow <= w_shadow;
        r_div0   <= w_is_div && (i_rt == 32'd0);
        r_cnt    <= w_cycles;
        r_busy   <= 1'b1;
      end else if (i_op == OP_MTHI) begin
        r_hi <= i_rs;
      end else if (i_op == OP_MTLO) begin
        r_lo <= i_rs;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_stall_req = i_start | r_busy;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv with hand-computed HI/LO results and busy-window lengths.
// Covers both builds of the accumulate feature (MULDIV_MADD_EN defined or not).
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n_busy;

  always #5 clk = ~clk;

  ex_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_rs(rs), .i_rt(rt),
    .o_busy(busy), .o_stall_req(stall_req), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single edge; returns #1 after the acceptance edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    #1;
    chk("stall_on_start", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'd0; rs = 32'd0; rt = 32'd0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);

    // MULT -3 * 5 = -15
    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    chk("mult_busy_after_accept", {31'd0, busy}, 32'd1);
    chk("mult_hi_held_in_window", hi, 32'd0);
    wait_idle(n_busy);
    chk("mult_busy_cycles", n_busy, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    chk("mult_stall_after", {31'd0, stall_req}, 32'd0);

    issue(4'd2, 32'hFFFFFFFD, 32'd5);
    wait_idle(n_busy);
    chk("multu_busy_cycles", n_busy, 32'd5);
    chk("multu_hi", hi, 32'h00000004);
    chk("multu_lo", lo, 32'hFFFFFFF1);

    issue(4'd4, 32'd100, 32'd7);
    wait_idle(n_busy);
    chk("divu_busy_cycles", n_busy, 32'd10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // -7 / 2 = -3 rem -1
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n_busy);
    chk("div_busy_cycles", n_busy, 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n_busy);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    issue(4'd5, 32'h00001234, 32'd0);
    chk("mthi_no_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h00001234);
    chk("mthi_lo_kept", lo, 32'h80000000);

    issue(4'd3, 32'd55, 32'd0);
    wait_idle(n_busy);
    chk("div0_busy_cycles", n_busy, 32'd10);
    chk("div0_hi_kept", hi, 32'h00001234);
    chk("div0_lo_kept", lo, 32'h80000000);

    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    chk("mtlo_lo", lo, 32'hFFFFFFFF);
    issue(4'd5, 32'd0, 32'd0);
    chk("mthi_zero", hi, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle(n_busy);
`ifdef MULDIV_MADD_EN
    chk("maddu_busy_cycles", n_busy, 32'd5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    chk("maddu_off_busy", n_busy, 32'd0);
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    // Hold start with MTLO through an active MULT window; it must be ignored.
    issue(4'd1, 32'd7, 32'd6);
    start = 1'b1; op = 4'd6; rs = 32'h00000BAD; rt = 32'd0;
    wait_idle(n_busy);
    start = 1'b0; op = 4'd0;
    chk("ignore_busy_cycles", n_busy, 32'd5);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd42);

    // Asynchronous reset in the middle of a MULT window.
    issue(4'd1, 32'd3, 32'd3);
    @(posedge clk); #1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #2 rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("rst_no_commit_lo", lo, 32'd0);
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
